// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the three-port SDRAM burst-port arbiter: state encoding,
// requester indices and the default read burst length.
package sdram_port_arbiter_pkg;

    localparam int BURST_LEN_DEFAULT = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_RD = 3'd1;
    localparam logic [2:0] ST_BURST   = 3'd2;
    localparam logic [2:0] ST_WAIT_WR = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [1:0] PORT_ICACHE = 2'd0;
    localparam logic [1:0] PORT_DCACHE = 2'd1;
    localparam logic [1:0] PORT_WRITE  = 2'd2;

    // Successor in the round-robin ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        case (p)
            PORT_ICACHE: return PORT_DCACHE;
            PORT_DCACHE: return PORT_WRITE;
            default:     return PORT_ICACHE;
        endcase
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters; the search starts at ptr
// and walks ptr, ptr+1, ptr+2 (mod 3), returning the first asserted request.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [3:0] req_ext;
    logic [1:0] cand [3];
    logic [2:0] hit;

    assign req_ext = {1'b0, req};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            logic [2:0] sum;
            assign sum        = {1'b0, ptr} + 3'(gi);
            assign cand[gi]   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            assign hit[gi]    = req_ext[cand[gi]];
        end
    endgenerate

    assign valid = |hit;
    assign idx   = hit[0] ? cand[0] : (hit[1] ? cand[1] : cand[2]);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Non-preemptive round-robin arbiter sharing one SDRAM controller burst port between
// the I-cache, D-cache and uncached write path; grant is held for the whole transaction.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p2_req,
    input  logic              p0_rw,
    input  logic              p1_rw,
    input  logic              p2_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [15:0]       p0_wdata,
    input  logic [15:0]       p1_wdata,
    input  logic [15:0]       p2_wdata,
    output logic              p0_fill,
    output logic              p1_fill,
    output logic              p2_fill,
    output logic              p0_ack,
    output logic              p1_ack,
    output logic              p2_ack,
    output logic [15:0]       rdata,
    output logic              sdram_req,
    output logic              sdram_rw,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [15:0]       sdram_wdata,
    input  logic              sdram_fill,
    input  logic              sdram_ack,
    input  logic [15:0]       sdram_rdata
);

    logic [2:0]        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        beat_q, beat_d;
    logic              sdram_req_q, sdram_req_d;
    logic              sdram_rw_q, sdram_rw_d;
    logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
    logic [15:0]       sdram_wdata_q, sdram_wdata_d;

    logic [2:0]        req_vec;
    logic              rw_arr    [4];
    logic [ADDR_W-1:0] addr_arr  [4];
    logic [15:0]       wdata_arr [4];
    logic              pick_valid;
    logic [1:0]        pick_idx;

    assign req_vec = {p2_req, p1_req, p0_req};

    // Entry 3 is never selected; it only keeps the 2-bit index in range.
    assign rw_arr[0]    = p0_rw;
    assign rw_arr[1]    = p1_rw;
    assign rw_arr[2]    = p2_rw;
    assign rw_arr[3]    = 1'b0;
    assign addr_arr[0]  = p0_addr;
    assign addr_arr[1]  = p1_addr;
    assign addr_arr[2]  = p2_addr;
    assign addr_arr[3]  = '0;
    assign wdata_arr[0] = p0_wdata;
    assign wdata_arr[1] = p1_wdata;
    assign wdata_arr[2] = p2_wdata;
    assign wdata_arr[3] = '0;

    rr_pick3 u_pick (
        .req   (req_vec),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        beat_d        = beat_q;
        sdram_req_d   = sdram_req_q;
        sdram_rw_d    = sdram_rw_q;
        sdram_addr_d  = sdram_addr_q;
        sdram_wdata_d = sdram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sdram_req_d   = 1'b1;
                    sdram_rw_d    = rw_arr[pick_idx];
                    sdram_addr_d  = addr_arr[pick_idx];
                    sdram_wdata_d = wdata_arr[pick_idx];
                    grant_d       = 3'b001 << pick_idx;
                    rr_ptr_d      = next_port(pick_idx);
                    state_d       = rw_arr[pick_idx] ? ST_WAIT_RD : ST_WAIT_WR;
                end
            end
            ST_WAIT_RD: begin
                if (sdram_fill) begin
                    sdram_req_d = 1'b0;
                    if (BURST_LEN == 1) begin
                        grant_d = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        beat_d  = 4'(BURST_LEN - 1);
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                // Counter holds the number of beats still to come, including this one.
                beat_d = beat_q - 4'd1;
                if (beat_q == 4'd1) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_WAIT_WR: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    grant_d     = '0;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d     = '0;
                sdram_req_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= PORT_ICACHE;
            beat_q        <= '0;
            sdram_req_q   <= 1'b0;
            sdram_rw_q    <= 1'b0;
            sdram_addr_q  <= '0;
            sdram_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_q        <= beat_d;
            sdram_req_q   <= sdram_req_d;
            sdram_rw_q    <= sdram_rw_d;
            sdram_addr_q  <= sdram_addr_d;
            sdram_wdata_q <= sdram_wdata_d;
        end
    end

    // Strobes reach only the granted port and only in a state that expects them.
    logic       fill_en, ack_en;
    logic [2:0] fill_vec, ack_vec;

    assign fill_en = (state_q == ST_WAIT_RD) || (state_q == ST_BURST);
    assign ack_en  = (state_q == ST_WAIT_WR);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_route
            assign fill_vec[gi] = sdram_fill & fill_en & grant_q[gi];
            assign ack_vec[gi]  = sdram_ack & ack_en & grant_q[gi];
        end
    endgenerate

    assign p0_fill     = fill_vec[0];
    assign p1_fill     = fill_vec[1];
    assign p2_fill     = fill_vec[2];
    assign p0_ack      = ack_vec[0];
    assign p1_ack      = ack_vec[1];
    assign p2_ack      = ack_vec[2];
    assign rdata       = sdram_rdata;
    assign sdram_req   = sdram_req_q;
    assign sdram_rw    = sdram_rw_q;
    assign sdram_addr  = sdram_addr_q;
    assign sdram_wdata = sdram_wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: the bench plays requesters and SDRAM controller, and a
// round-robin reference model predicts which port each transaction belongs to.
module tb_sdram_port_arbiter;
    import sdram_port_arbiter_pkg::*;

    localparam int BL = BURST_LEN_DEFAULT;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          p0_req, p1_req, p2_req, p0_rw, p1_rw, p2_rw;
    logic [AW-1:0] p0_addr, p1_addr, p2_addr;
    logic [15:0]   p0_wdata, p1_wdata, p2_wdata;
    logic          p0_fill, p1_fill, p2_fill, p0_ack, p1_ack, p2_ack;
    logic [15:0]   rdata;
    logic          sdram_req, sdram_rw;
    logic [AW-1:0] sdram_addr;
    logic [15:0]   sdram_wdata;
    logic          sdram_fill, sdram_ack;
    logic [15:0]   sdram_rdata;

    // Second instance built with single-word bursts
    logic          b_p0_req, b_p1_req, b_fill;
    logic [15:0]   b_rdata_in;
    logic          b_p0_fill, b_p1_fill, b_p2_fill, b_p0_ack, b_p1_ack, b_p2_ack;
    logic [15:0]   b_rdata;
    logic          b_sreq, b_srw;
    logic [AW-1:0] b_saddr;
    logic [15:0]   b_swdata;

    sdram_port_arbiter #(.BURST_LEN(BL), .ADDR_W(AW)) u_dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p1_req(p1_req), .p2_req(p2_req),
        .p0_rw(p0_rw), .p1_rw(p1_rw), .p2_rw(p2_rw),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p2_addr(p2_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p2_wdata(p2_wdata),
        .p0_fill(p0_fill), .p1_fill(p1_fill), .p2_fill(p2_fill),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .p2_ack(p2_ack),
        .rdata(rdata),
        .sdram_req(sdram_req), .sdram_rw(sdram_rw),
        .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
        .sdram_fill(sdram_fill), .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata)
    );

    sdram_port_arbiter #(.BURST_LEN(1), .ADDR_W(AW)) u_dut_bl1 (
        .clk(clk), .reset(reset),
        .p0_req(b_p0_req), .p1_req(b_p1_req), .p2_req(1'b0),
        .p0_rw(1'b1), .p1_rw(1'b1), .p2_rw(1'b1),
        .p0_addr(32'h0000_0040), .p1_addr(32'h0000_0084), .p2_addr(32'h0000_0000),
        .p0_wdata(16'h0000), .p1_wdata(16'h0000), .p2_wdata(16'h0000),
        .p0_fill(b_p0_fill), .p1_fill(b_p1_fill), .p2_fill(b_p2_fill),
        .p0_ack(b_p0_ack), .p1_ack(b_p1_ack), .p2_ack(b_p2_ack),
        .rdata(b_rdata),
        .sdram_req(b_sreq), .sdram_rw(b_srw),
        .sdram_addr(b_saddr), .sdram_wdata(b_swdata),
        .sdram_fill(b_fill), .sdram_ack(1'b0), .sdram_rdata(b_rdata_in)
    );

    // Reference model: pending request table plus round-robin pointer
    logic          req_m   [3];
    logic          rw_m    [3];
    logic [AW-1:0] addr_m  [3];
    logic [15:0]   wdata_m [3];
    int            rr_m;
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            end_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] fills();
        return {p2_fill, p1_fill, p0_fill};
    endfunction

    function automatic logic [2:0] acks();
        return {p2_ack, p1_ack, p0_ack};
    endfunction

    function automatic int pick_model();
        for (int k = 0; k < 3; k++)
            if (req_m[(rr_m + k) % 3]) return (rr_m + k) % 3;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        p0_req = req_m[0]; p0_rw = rw_m[0]; p0_addr = addr_m[0]; p0_wdata = wdata_m[0];
        p1_req = req_m[1]; p1_rw = rw_m[1]; p1_addr = addr_m[1]; p1_wdata = wdata_m[1];
        p2_req = req_m[2]; p2_rw = rw_m[2]; p2_addr = addr_m[2]; p2_wdata = wdata_m[2];
    endtask

    task automatic set_req(input int p, input logic rw, input logic [AW-1:0] a, input logic [15:0] wd);
        req_m[p] = 1'b1; rw_m[p] = rw; addr_m[p] = a; wdata_m[p] = wd;
    endtask

    task automatic set_rand_req(input int p, input logic rw);
        logic [31:0] r;
        r = $urandom();
        set_req(p, rw, {r[31:2], 2'(p)}, 16'($urandom()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            apply();
            @(negedge clk);
        end
    endtask

    // Wait for the next grant, check it against the model, then act as the controller.
    // mode 1: expect sdram_req one cycle after the request; mode 2: expect the 3-cycle turnaround.
    task automatic serve(input int mode, input int dly, input logic [15:0] w0,
                         input bit spur, input int raise_p, input bit rst_b2);
        int exp_p;
        int start_cyc;
        bit found;
        found = 1'b0;
        start_cyc = 0;
        exp_p = pick_model();
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            sdram_fill = 1'b0; sdram_ack = 1'b0;
            apply();
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            if (sdram_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("grant_seen", 64'(found), 64'd1);
        if (!found || exp_p < 0) return;
        if (mode == 1) chk("req_latency", 64'(cyc - start_cyc), 64'd1);
        if (mode == 2) chk("turnaround", 64'(cyc - end_cyc), 64'd3);
        chk("sdram_addr", 64'(sdram_addr), 64'(addr_m[exp_p]));
        chk("sdram_rw", 64'(sdram_rw), 64'(rw_m[exp_p]));
        if (!rw_m[exp_p]) chk("sdram_wdata", 64'(sdram_wdata), 64'(wdata_m[exp_p]));
        $display("txn %s port=%0d addr=%h delay=%0d", rw_m[exp_p] ? "RD" : "WR", exp_p, addr_m[exp_p], dly);
        rr_m = (exp_p + 1) % 3;

        for (int d = 0; d < dly; d++) begin
            next_cycle();
            sdram_fill = 1'b0; sdram_ack = 1'b0;
            if (spur && d == 0) begin
                if (rw_m[exp_p]) sdram_ack = 1'b1;
                else             sdram_fill = 1'b1;
            end
            @(negedge clk);
            chk("hold_req", 64'(sdram_req), 64'd1);
            chk(spur && d == 0 ? "spurious_masked" : "quiet", 64'({fills(), acks()}), 64'd0);
        end

        if (rw_m[exp_p]) begin
            next_cycle();
            sdram_ack = 1'b0; sdram_fill = 1'b1; sdram_rdata = w0;
            @(negedge clk);
            chk("fill_route", 64'(fills()), 64'(3'b001 << exp_p));
            chk("rdata_w0", 64'(rdata), 64'(w0));
            end_cyc = cyc;
            for (int b = 1; b < BL; b++) begin
                next_cycle();
                sdram_fill = 1'b0;
                sdram_rdata = 16'(w0 + b);
                if (b == 1) req_m[exp_p] = 1'b0;
                if (b == 1 && rst_b2) reset = 1'b1;
                if (b == 2 && raise_p >= 0) set_rand_req(raise_p, 1'b1);
                apply();
                @(negedge clk);
                chk("rdata_beat", 64'(rdata), 64'(16'(w0 + b)));
                chk("beat_fill_quiet", 64'(fills()), 64'd0);
                chk("beat_req_low", 64'(sdram_req), 64'd0);
                end_cyc = cyc;
                if (b == 1 && rst_b2) begin
                    next_cycle();
                    sdram_fill = 1'b1;
                    @(negedge clk);
                    chk("rst_req_low", 64'(sdram_req), 64'd0);
                    chk("rst_addr_zero", 64'(sdram_addr), 64'd0);
                    chk("rst_fill_masked", 64'(fills()), 64'd0);
                    next_cycle();
                    reset = 1'b0; sdram_fill = 1'b0;
                    rr_m = 0;
                    for (int p = 0; p < 3; p++) req_m[p] = 1'b0;
                    apply();
                    @(negedge clk);
                    $display("txn reset mid-burst port=%0d", exp_p);
                    return;
                end
            end
        end else begin
            next_cycle();
            sdram_fill = 1'b0; sdram_ack = 1'b1;
            @(negedge clk);
            chk("ack_route", 64'(acks()), 64'(3'b001 << exp_p));
            chk("ack_fill_quiet", 64'(fills()), 64'd0);
            end_cyc = cyc;
            next_cycle();
            sdram_ack = 1'b0;
            req_m[exp_p] = 1'b0;
            apply();
            @(negedge clk);
            chk("req_drop_after_ack", 64'(sdram_req), 64'd0);
            chk("ack_once", 64'(acks()), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        sdram_fill = 1'b0; sdram_ack = 1'b0; sdram_rdata = '0;
        b_p0_req = 1'b0; b_p1_req = 1'b0; b_fill = 1'b0; b_rdata_in = '0;
        rr_m = 0;
        for (int p = 0; p < 3; p++) begin
            req_m[p] = 1'b0; rw_m[p] = 1'b0; addr_m[p] = '0; wdata_m[p] = '0;
        end
        apply();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sdram_req", 64'(sdram_req), 64'd0);
        chk("reset_regs", 64'({sdram_rw, sdram_addr, sdram_wdata}), 64'd0);
        chk("reset_strobes", 64'({fills(), acks()}), 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);

        // Strobes while idle are dropped
        next_cycle();
        sdram_fill = 1'b1; sdram_ack = 1'b1;
        @(negedge clk);
        chk("idle_strobes_masked", 64'({fills(), acks()}), 64'd0);
        chk("idle_no_req", 64'(sdram_req), 64'd0);
        next_cycle();
        sdram_fill = 1'b0; sdram_ack = 1'b0;
        @(negedge clk);

        // Single read on the I-cache port
        set_req(0, 1'b1, 32'h0000_1238, 16'h0000);
        serve(1, 5, 16'hA001, 1'b0, -1, 1'b0);

        // Three simultaneous reads, then p0 and p2 together
        idle(2);
        for (int p = 0; p < 3; p++) set_rand_req(p, 1'b1);
        serve(1, $urandom_range(0, 4), 16'($urandom()), 1'b0, -1, 1'b0);
        serve(2, $urandom_range(0, 4), 16'($urandom()), 1'b0, -1, 1'b0);
        serve(2, $urandom_range(0, 4), 16'($urandom()), 1'b0, -1, 1'b0);
        idle(2);
        set_rand_req(0, 1'b1);
        set_rand_req(2, 1'b1);
        serve(1, $urandom_range(0, 4), 16'($urandom()), 1'b0, -1, 1'b0);
        serve(2, $urandom_range(0, 4), 16'($urandom()), 1'b0, -1, 1'b0);

        // Write on port 2 with a stray fill while waiting for the ack
        idle(2);
        set_req(2, 1'b0, 32'h0000_0100, 16'hBEEF);
        serve(1, 3, 16'h0000, 1'b1, -1, 1'b0);

        // p1 raises its request during p0's burst; stray ack during p0's wait
        idle(2);
        set_rand_req(0, 1'b1);
        serve(1, 3, 16'($urandom()), 1'b1, 1, 1'b0);
        serve(2, $urandom_range(0, 4), 16'($urandom()), 1'b0, -1, 1'b0);

        // Reset on the second burst word of a p1 read
        idle(2);
        set_rand_req(1, 1'b1);
        serve(1, 2, 16'($urandom()), 1'b0, -1, 1'b1);
        for (int p = 0; p < 3; p++) set_rand_req(p, 1'b1);
        serve(1, $urandom_range(0, 3), 16'($urandom()), 1'b0, -1, 1'b0);
        serve(2, $urandom_range(0, 3), 16'($urandom()), 1'b0, -1, 1'b0);
        serve(2, $urandom_range(0, 3), 16'($urandom()), 1'b0, -1, 1'b0);

        // Random mixed traffic
        for (int it = 0; it < 14; it++) begin
            bit any;
            int dly;
            any = 1'b0;
            for (int p = 0; p < 3; p++) begin
                if (!req_m[p] && $urandom_range(0, 1) == 1)
                    set_rand_req(p, 1'($urandom_range(0, 1)));
                if (req_m[p]) any = 1'b1;
            end
            if (!any) set_rand_req($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            dly = $urandom_range(0, 4);
            serve(2, dly, 16'($urandom()), (dly > 0) ? 1'($urandom_range(0, 1)) : 1'b0, -1, 1'b0);
        end
        for (int p = 0; p < 3; p++) req_m[p] = 1'b0;
        idle(1);

        // Single-word burst build: fill goes straight to release
        next_cycle();
        b_p0_req = 1'b1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("bl1_req", 64'(b_sreq), 64'd1);
        chk("bl1_addr0", 64'(b_saddr), 64'h40);
        next_cycle();
        b_fill = 1'b1; b_rdata_in = 16'h5A5A; b_p1_req = 1'b1;
        @(negedge clk);
        chk("bl1_fill_route", 64'({b_p2_fill, b_p1_fill, b_p0_fill}), 64'b001);
        chk("bl1_rdata", 64'(b_rdata), 64'h5A5A);
        next_cycle();
        b_fill = 1'b0; b_p0_req = 1'b0;
        @(negedge clk);
        chk("bl1_release_req_low", 64'(b_sreq), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("bl1_idle_req_low", 64'(b_sreq), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("bl1_next_grant", 64'(b_sreq), 64'd1);
        chk("bl1_addr1", 64'(b_saddr), 64'h84);
        next_cycle();
        b_fill = 1'b1;
        @(negedge clk);
        chk("bl1_fill_route_p1", 64'({b_p2_fill, b_p1_fill, b_p0_fill}), 64'b010);
        next_cycle();
        b_fill = 1'b0; b_p1_req = 1'b0;
        @(negedge clk);
        $display("txn BL1 reads ports 0 and 1 done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
